// File: rtl/nibble_comp_seq.sv
`default_nettype none
// ============================================================================
// Module      : nibble_comp_seq
// Description : Compares two WIDTH-bit unsigned operands using one external
//               4-bit cascadable magnitude-comparator slice. One nibble pair is
//               presented per clock, MSB nibble first. The previous slice
//               response is fed back on the cascade inputs. The sequencer can
//               stop early once the outcome is decided. A registered GT/EQ/LT
//               result is reported with a start/busy/done handshake.
// Ports       : clk, rst (async, active high)
//               start, a, b          - request and operands (captured on accept)
//               busy, done           - in-progress flag, one-cycle result pulse
//               a_gt_b/a_eq_b/a_lt_b - registered result, held until next compare
//               err                  - slice gave a non-one-hot response
//               slice_a/slice_b      - nibble pair presented to the slice
//               slice_in_gt/eq/lt    - cascade inputs to the slice
//               slice_out_gt/eq/lt   - slice response
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_comp_seq #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             err,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_in_gt,
    output logic             slice_in_eq,
    output logic             slice_in_lt,
    input  logic             slice_out_gt,
    input  logic             slice_out_eq,
    input  logic             slice_out_lt
);

    localparam int c_NIB   = WIDTH / 4;
    localparam int c_IDX_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(c_NIB - 1);

    // Cascade / result encodings, ordered {gt, eq, lt}.
    localparam logic [2:0] c_CASC_GT = 3'b100;
    localparam logic [2:0] c_CASC_EQ = 3'b010;
    localparam logic [2:0] c_CASC_LT = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]     a_q,     a_d;
    logic [WIDTH-1:0]     b_q,     b_d;
    logic [2:0]           casc_q,  casc_d;
    logic [2:0]           res_q,   res_d;
    logic                 err_q,   err_d;
    logic                 done_q,  done_d;

    logic [2:0]           w_resp;
    logic                 w_onehot;
    logic [2:0]           w_capt;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_shift;
    logic [WIDTH-1:0]     w_b_shift;

    // Slice response conditioning: anything that is not exactly one-hot is
    // treated as LT so the result stays mutually exclusive.
    assign w_resp   = {slice_out_gt, slice_out_eq, slice_out_lt};
    assign w_onehot = (w_resp == c_CASC_GT) || (w_resp == c_CASC_EQ) ||
                      (w_resp == c_CASC_LT);
    assign w_capt   = w_onehot ? w_resp : c_CASC_LT;
    assign w_last   = (idx_q == '0) || (EARLY_EXIT && (w_capt != c_CASC_EQ));

    // Nibble selection from the captured operands only; the slice outputs
    // never feed back into the slice inputs within a cycle.
    assign w_a_shift = a_q >> {idx_q, 2'b00};
    assign w_b_shift = b_q >> {idx_q, 2'b00};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = c_IDX_MAX;
                    casc_d  = c_CASC_EQ;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                casc_d = w_capt;
                if (!w_onehot) begin
                    err_d = 1'b1;
                end
                if (w_last) begin
                    res_d   = w_capt;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign a_gt_b  = res_q[2];
    assign a_eq_b  = res_q[1];
    assign a_lt_b  = res_q[0];
    assign err     = err_q;

    assign slice_a = busy ? w_a_shift[3:0] : 4'h0;
    assign slice_b = busy ? w_b_shift[3:0] : 4'h0;

    // Idle drive is a neutral EQ cascade; during RUN the cascade register.
    assign {slice_in_gt, slice_in_eq, slice_in_lt} = busy ? casc_q : c_CASC_EQ;

endmodule
`default_nettype wire

// File: doc/nibble_comp_seq.md
Name: nibble_comp_seq

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands with one shared external 4-bit cascadable magnitude-comparator slice.
- Feeds the slice one nibble pair per clock, MSB nibble first, and feeds the previous result back into the slice's cascade inputs.
- Exits early once the result is decided and reports a registered GT/EQ/LT result with a start/done handshake.
- Sits between a requester (e.g. sorter or limit checker) and the comparator slice, so wide compares need no wide comparator.

Parameters:
- WIDTH, 16, operand width in bits; multiple of 4, minimum 4; NIB = WIDTH/4 nibbles.
- EARLY_EXIT, 1, 1 = finish on the first non-equal nibble; 0 = always run all NIB nibbles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse; result valid.
- a_gt_b  out  1  registered result A>B; held until the next accepted start.
- a_eq_b  out  1  registered result A==B; held until the next accepted start.
- a_lt_b  out  1  registered result A<B; held until the next accepted start.
- err  out  1  slice returned a non-one-hot response during the last compare; held with the result.
- slice_a  out  4  nibble of A presented to the slice.
- slice_b  out  4  nibble of B presented to the slice.
- slice_in_gt  out  1  cascade input "greater" to the slice.
- slice_in_eq  out  1  cascade input "equal" to the slice.
- slice_in_lt  out  1  cascade input "less" to the slice.
- slice_out_gt  in  1  slice result "greater" (combinational from the slice inputs).
- slice_out_eq  in  1  slice result "equal".
- slice_out_lt  in  1  slice result "less".

Behaviour:
- Reset: asynchronous on rst=1; applies immediately at any time.
  - Reset values: state=IDLE, busy=0, done=0, a_gt_b=a_eq_b=a_lt_b=0, err=0.
  - Internal index and cascade registers are cleared.
  - Reset during RUN aborts the compare with no done pulse.
- Slice contract, which the controller relies on:
  - Cascade in = EQ: the slice compares its nibbles.
  - Cascade in = GT: the slice passes GT through.
  - Any other cascade value: the slice returns LT.
- State IDLE:
  - busy=0; slice_a=slice_b=0; cascade outputs = (0,1,0).
  - On start=1: capture a and b, set idx=NIB-1, set cascade register = EQ (0,1,0), clear err, move to RUN.
  - Result outputs keep their old values until the compare completes.
- State RUN:
  - busy=1; slice_a=A[4*idx+3:4*idx]; slice_b=B[4*idx+3:4*idx]; cascade outputs = cascade register.
  - All slice drive signals come from registers only, so the loop through the slice has no combinational path back.
  - Each rising edge captures the slice response into the cascade register.
  - A response that is not exactly one-hot is captured as LT (0,0,1) and sets err.
- Terminating a compare:
  - Terminate when idx==0, or when EARLY_EXIT=1 and the captured response is not EQ.
  - On termination: load a_gt_b/a_eq_b/a_lt_b from the captured response, pulse done for the following cycle, return to IDLE.
  - Otherwise decrement idx and stay in RUN.
- Latency, with start accepted at edge 0:
  - RUN occupies cycles 1..k, where k = nibbles used.
  - done is high in cycle k+1, with results valid that cycle.
  - Worst case k = NIB; with early exit, k = index of the first differing nibble counted from the MSB, starting at 1.
- done cycle: the state is IDLE in this cycle.
  - A start here is accepted, giving back-to-back compares with no bubble.
  - done still pulses for exactly one cycle.
- start while busy=1: ignored; it is not queued, and the operands are not recaptured.
- Changes on a/b while busy: no effect, because the operands are captured on the accepted start.
- Results are mutually exclusive; after the first completed compare exactly one of gt/eq/lt is 1.
- Ordering is unsigned only.
- EQ can only result after all NIB nibbles are processed, in both modes.

Test Plan (WIDTH=16, behavioural slice model unless noted):
1. a=16'h1234, b=16'h1234, start at edge 0 -> busy cycles 1-4, done in cycle 5, eq=1, gt=lt=0, err=0.
2. EARLY_EXIT=1, a=16'h8000, b=16'h7FFF -> done in cycle 2, gt=1; repeat with EARLY_EXIT=0 -> done in cycle 5, gt=1.
3. a=16'h1230, b=16'h1231 -> 4 RUN cycles, lt=1. Then start held high in the done cycle with a=16'hFFFF, b=16'h0000 -> accepted with no gap, done 2 cycles later, gt=1.
4. start pulses on cycles 2 and 3 during a compare of 16'h0001 vs 16'h0002 -> a single done only, lt=1, and the operands stay unchanged.
5. Assert rst in cycle 2 of a RUN -> busy=0, done=0, result=000, err=0 immediately. The next start completes normally.
6. Slice model forced to return (1,1,0) on the second nibble -> err=1 and lt=1 at done; err clears on the next accepted start.
